mac_rx_classifier: RTL and testbench
====================================

Name: mac_rx_classifier

Overview:
Parametrised successor to the single-purpose MAC RX front-end. It takes the raw GMII-style byte stream and performs preamble/SFD detection, destination-MAC filtering and EtherType classification against a table of NUM_CH entries. It strips the header and FCS, checks CRC-32 and length, and emits the payload as a byte stream tagged with a channel index. Downstream IP, ARP and other protocol engines attach per channel, which removes the need for a fixed IP/ARP-only split.

Parameters:
NUM_CH, 4, number of EtherType channels.
CH_W, 2, width of the channel index; must be at least clog2(NUM_CH).
CH_ETYPE, {16'h88F7,16'h86DD,16'h0806,16'h0800}, packed table; channel i matches CH_ETYPE[16*i+:16], so channel 0 is IPv4.
MIN_LEN, 64, minimum frame length in bytes, counted from dst MAC through FCS.
MAX_LEN, 1522, maximum frame length in bytes, same counting.

Ports:
clk  in  1  clock, one byte per cycle while rx_dv=1.
rst  in  1  asynchronous reset, active-high.
rx_dv  in  1  frame data valid; continuous within a frame.
rx_data  in  8  receive byte.
local_mac_addr  in  48  unicast address to accept.
promisc  in  1  1 = accept any destination MAC.
out_valid  out  1  payload byte valid.
out_data  out  8  payload byte.
out_sop  out  1  first payload byte of the frame.
out_eop  out  1  last payload byte of the frame.
out_err  out  1  qualifies out_eop: frame bad (CRC, runt or oversize).
out_ch  out  CH_W  channel index; stable from sop through eop.
out_src_mac  out  48  source MAC; latched at end of header, stable until next sop.
out_vlan_id  out  12  VLAN ID; see Optional Feature.
stat_good  out  1  1-cycle pulse: frame closed with err=0.
stat_bad  out  1  1-cycle pulse: frame closed with err=1.
stat_drop  out  1  1-cycle pulse: frame filtered (MAC or EtherType miss, bad preamble, runt header).

Behaviour:
- Reset: all outputs 0; state IDLE; shift buffer, counters and CRC cleared. Reset mid-frame discards the frame with no eop and no stat pulse. Reception resumes only at a fresh preamble.
- No backpressure: consumer must accept at line rate.
- States: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP.
- IDLE: rx_dv=1 with byte 0x55 -> PREAMBLE. rx_dv=1 with any other byte -> DROP.
- PREAMBLE:
  - 0x55 -> stay.
  - 0xD5 -> HEADER; CRC set to 0xFFFFFFFF; byte count 0.
  - Any other byte -> DROP.
  - rx_dv=0 -> IDLE, with no pulse.
- HEADER: capture 14 bytes (dst 6, src 6, type 2). On the last header byte:
  - Accept iff dst==local_mac_addr, or dst==48'hFFFFFFFFFFFF, or promisc=1.
  - AND EtherType equals some CH_ETYPE entry; the lowest matching index wins.
  - Accept -> PAYLOAD. Reject -> DROP plus stat_drop.
  - rx_dv=0 during HEADER -> IDLE plus stat_drop.
- CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, updated on every byte from dst through FCS. CRC is good iff the register equals 0xDEBB20E3 after the last byte.
- PAYLOAD:
  - Incoming bytes enter a 5-stage byte shift buffer.
  - Once 5 bytes are buffered, each new byte pushes stage 5 out as out_valid with out_data. Latency from payload byte in to out_data is 5 cycles. out_sop is set on the first byte pushed out.
- Frame end (first cycle in PAYLOAD with rx_dv=0):
  - If at least 5 bytes are buffered, stage 5 is output with out_eop=1. out_err=1 if CRC is bad or byte count < MIN_LEN.
  - Stats: if out_err=0, stat_good on the same cycle; otherwise stat_bad.
  - If no payload byte has yet been output, out_sop and out_eop are both set on that byte.
  - If fewer than 5 bytes are buffered (no payload after FCS removal): nothing is output; stat_drop fires.
  - State -> IDLE.
- Oversize: byte count exceeding MAX_LEN while in PAYLOAD -> the next cycle outputs stage 5 with out_eop=1, out_err=1 and stat_bad, then DROP.
- DROP: outputs idle; rx_dv=0 -> IDLE.
- Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient.
- Counters: byte count is 11 bits and saturates at 2047.

Optional Feature:
Macro: MAC_RX_VLAN_EN.
- Defined: when the EtherType is 0x8100, capture the 2-byte TCI and use the following 2 bytes as the classifying EtherType; the header becomes 18 bytes. out_vlan_id = TCI[11:0], latched with out_src_mac; untagged frames give 0.
- Undefined: 0x8100 is classified only if present in CH_ETYPE, no tag stripping; out_vlan_id tied to 0.

Test Plan:
- 7x55+D5, dst=local, type 0x0800, 46-byte payload, good FCS -> 46 out_valid beats with out_ch=0, sop on beat 1, eop on beat 46, out_err=0, stat_good once, out_src_mac matches the frame.
- Broadcast ARP frame (type 0x0806, 46 bytes) with one FCS bit flipped -> out_ch=1, eop with out_err=1, stat_bad.
- dst=02:00:00:00:00:99 not local, promisc=0 -> no out_valid, stat_drop; repeat with promisc=1 -> frame delivered.
- Type 0x1234 -> stat_drop; preamble containing 0x5A -> DROP with no outputs.
- 1600-byte frame -> eop with out_err=1 after 1522 counted bytes, then silence until rx_dv falls.
- Assert rst mid-payload -> all outputs 0 immediately; next good frame delivered normally. With MAC_RX_VLAN_EN, tagged 0x8100/VID 0x05A/0x0800 frame -> out_ch=0, out_vlan_id=0x05A.

Source files
------------

// File: rtl/mac_rx_classifier.sv
// GMII-style MAC receive front-end: preamble/SFD detect, destination filter, EtherType
// classification, FCS/length check and header/FCS stripping. Optional VLAN tag support: MAC_RX_VLAN_EN.
module mac_rx_classifier #(
  parameter int                   NUM_CH   = 4,
  parameter int                   CH_W     = 2,
  parameter logic [16*NUM_CH-1:0] CH_ETYPE = {16'h88F7, 16'h86DD, 16'h0806, 16'h0800},
  parameter int                   MIN_LEN  = 64,
  parameter int                   MAX_LEN  = 1522
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_dv,
  input  logic [7:0]      rx_data,
  input  logic [47:0]     local_mac_addr,
  input  logic            promisc,
  output logic            out_valid,
  output logic [7:0]      out_data,
  output logic            out_sop,
  output logic            out_eop,
  output logic            out_err,
  output logic [CH_W-1:0] out_ch,
  output logic [47:0]     out_src_mac,
  output logic [11:0]     out_vlan_id,
  output logic            stat_good,
  output logic            stat_bad,
  output logic            stat_drop
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] CNT_MAX     = 11'h7FF;

  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [10:0] cnt_sat_inc(input logic [10:0] c);
    return (c == CNT_MAX) ? c : c + 11'd1;
  endfunction

  state_t          state;
  logic [10:0]     bcnt;
  logic [31:0]     crc;
  logic [103:0]    hdr;
  logic [7:0]      pl_buf [0:4];
  logic [2:0]      fill;
  logic            sop_pend;

  logic [47:0]     dst_w;
  logic [47:0]     src_w;
  logic [15:0]     etype_w;
  logic            hdr_done;
  logic            mac_ok;
  logic            ch_hit;
  logic [CH_W-1:0] ch_w;
  logic [31:0]     crc_w;
  logic            oversize;
  logic            frame_bad;

`ifdef MAC_RX_VLAN_EN
  logic            vlan_q;
  logic [47:0]     dst_q;
  logic [47:0]     src_q;
  logic [11:0]     vid_q;
  logic            tag_w;
  logic [11:0]     vid_w;
`endif

  // Header decode: hdr holds the previous 13 bytes, rx_data is the current one.
  always_comb begin
    dst_w    = hdr[103:56];
    src_w    = hdr[55:8];
    etype_w  = {hdr[7:0], rx_data};
    hdr_done = (bcnt == 11'd13);
`ifdef MAC_RX_VLAN_EN
    tag_w = 1'b0;
    vid_w = '0;
    if (vlan_q) begin
      dst_w    = dst_q;
      src_w    = src_q;
      vid_w    = hdr[19:8];
      hdr_done = (bcnt == 11'd17);
    end else if (hdr_done && etype_w == 16'h8100) begin
      tag_w    = 1'b1;
      hdr_done = 1'b0;
    end
`endif
    mac_ok = promisc || (dst_w == local_mac_addr) || (dst_w == 48'hFFFF_FFFF_FFFF);
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    ch_hit = 1'b0;
    ch_w   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (etype_w == CH_ETYPE[16*i +: 16]) begin
        ch_hit = 1'b1;
        ch_w   = CH_W'(i);
      end
    end
  end

  assign crc_w     = crc32_byte(crc, rx_data);
  assign oversize  = int'(bcnt) > MAX_LEN;
  assign frame_bad = (crc != CRC_RESIDUE) || (int'(bcnt) < MIN_LEN);

`ifdef MAC_RX_VLAN_EN
  assign out_vlan_id = vid_q;
`else
  assign out_vlan_id = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bcnt        <= '0;
      crc         <= '0;
      hdr         <= '0;
      fill        <= '0;
      sop_pend    <= 1'b0;
      for (int i = 0; i < 5; i++) pl_buf[i] <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_err     <= 1'b0;
      out_ch      <= '0;
      out_src_mac <= '0;
      stat_good   <= 1'b0;
      stat_bad    <= 1'b0;
      stat_drop   <= 1'b0;
`ifdef MAC_RX_VLAN_EN
      vlan_q      <= 1'b0;
      dst_q       <= '0;
      src_q       <= '0;
      vid_q       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      stat_good <= 1'b0;
      stat_bad  <= 1'b0;
      stat_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_dv) state <= (rx_data == 8'h55) ? PREAMBLE : DROP;
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rx_data == 8'hD5) begin
            state    <= HEADER;
            crc      <= 32'hFFFF_FFFF;
            bcnt     <= '0;
            fill     <= '0;
            sop_pend <= 1'b1;
`ifdef MAC_RX_VLAN_EN
            vlan_q   <= 1'b0;
`endif
          end else if (rx_data != 8'h55) begin
            state     <= DROP;
            stat_drop <= 1'b1;
          end
        end
        HEADER: begin
          if (!rx_dv) begin
            state     <= IDLE;
            stat_drop <= 1'b1;
          end else begin
            crc  <= crc_w;
            bcnt <= cnt_sat_inc(bcnt);
            hdr  <= {hdr[95:0], rx_data};
`ifdef MAC_RX_VLAN_EN
            if (tag_w) begin
              vlan_q <= 1'b1;
              dst_q  <= dst_w;
              src_q  <= src_w;
            end
`endif
            if (hdr_done) begin
              if (mac_ok && ch_hit) begin
                state       <= PAYLOAD;
                out_ch      <= ch_w;
                out_src_mac <= src_w;
`ifdef MAC_RX_VLAN_EN
                vid_q       <= vid_w;
`endif
              end else begin
                state     <= DROP;
                stat_drop <= 1'b1;
              end
            end
          end
        end
        // Five-byte delay line: the last four bytes held at frame end are the FCS.
        PAYLOAD: begin
          if (oversize) begin
            out_valid <= 1'b1;
            out_data  <= pl_buf[4];
            out_sop   <= sop_pend;
            out_eop   <= 1'b1;
            out_err   <= 1'b1;
            stat_bad  <= 1'b1;
            state     <= DROP;
          end else if (rx_dv) begin
            crc       <= crc_w;
            bcnt      <= cnt_sat_inc(bcnt);
            pl_buf[0] <= rx_data;
            for (int i = 1; i < 5; i++) pl_buf[i] <= pl_buf[i-1];
            if (fill == 3'd5) begin
              out_valid <= 1'b1;
              out_data  <= pl_buf[4];
              out_sop   <= sop_pend;
              sop_pend  <= 1'b0;
            end else begin
              fill <= fill + 3'd1;
            end
          end else begin
            if (fill == 3'd5) begin
              out_valid <= 1'b1;
              out_data  <= pl_buf[4];
              out_sop   <= sop_pend;
              out_eop   <= 1'b1;
              out_err   <= frame_bad;
              stat_good <= !frame_bad;
              stat_bad  <= frame_bad;
            end else begin
              stat_drop <= 1'b1;
            end
            state <= IDLE;
          end
        end
        DROP: begin
          if (!rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx_classifier.sv
// Directed bench for mac_rx_classifier: table of frames plus hand-written reset,
// back-to-back, bad-preamble and VLAN sequences.
module tb_mac_rx_classifier;
  localparam int CH_W = 2;
  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;

  logic            clk = 1'b0;
  logic            rst;
  logic            rx_dv;
  logic [7:0]      rx_data;
  logic [47:0]     local_mac_addr;
  logic            promisc;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_sop;
  logic            out_eop;
  logic            out_err;
  logic [CH_W-1:0] out_ch;
  logic [47:0]     out_src_mac;
  logic [11:0]     out_vlan_id;
  logic            stat_good;
  logic            stat_bad;
  logic            stat_drop;

  always #5 clk = ~clk;

  mac_rx_classifier dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data),
    .local_mac_addr(local_mac_addr), .promisc(promisc),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_err(out_err), .out_ch(out_ch), .out_src_mac(out_src_mac), .out_vlan_id(out_vlan_id),
    .stat_good(stat_good), .stat_bad(stat_bad), .stat_drop(stat_drop)
  );

  typedef struct {
    logic [47:0] dst;
    logic [15:0] et;
    int          plen;
    int          flip;
    logic        prom;
    int          beats;
    int          ch;
    logic        err;
    int          good;
    int          bad;
    int          drop;
  } vec_t;

  vec_t  vecs [14];
  string names [14];

  int total = 0;
  int bad_cnt = 0;

  logic [7:0] exp_q [$];
  int   mon_exp_ch;
  int   mon_beats, mon_eops, mon_sop_bad, mon_data_bad, mon_ch_bad;
  int   mon_good, mon_bad, mon_drop;
  logic mon_inframe, mon_err_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (mon_beats < exp_q.size()) begin
          if (out_data !== exp_q[mon_beats]) mon_data_bad++;
        end
        if (out_sop == mon_inframe) mon_sop_bad++;
        if (int'(out_ch) != mon_exp_ch) mon_ch_bad++;
        mon_inframe = !out_eop;
        if (out_eop) begin
          mon_eops++;
          mon_err_last = out_err;
        end
        mon_beats++;
      end
      if (stat_good) mon_good++;
      if (stat_bad)  mon_bad++;
      if (stat_drop) mon_drop++;
    end
  end

  task automatic clr_mon();
    mon_beats = 0; mon_eops = 0; mon_sop_bad = 0; mon_data_bad = 0; mon_ch_bad = 0;
    mon_good = 0; mon_bad = 0; mon_drop = 0; mon_inframe = 1'b0; mon_err_last = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_dv   = dv;
    rx_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  // Builds dst..FCS, appends the payload to exp_q, and sends it after a preamble.
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                            input int plen, input int flip, input int tci, input int seed,
                            input int bad_pre, input int stop_after);
    logic [7:0]  fr [$];
    logic [31:0] c;
    logic [15:0] t;
    logic [7:0]  p;
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
    if (tci >= 0) begin
      t = tci[15:0];
      fr.push_back(8'h81); fr.push_back(8'h00); fr.push_back(t[15:8]); fr.push_back(t[7:0]);
    end
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) begin
      p = 8'(seed + 13 * i);
      fr.push_back(p);
      exp_q.push_back(p);
    end
    c = 32'hFFFF_FFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    c = ~c ^ 32'(flip);
    fr.push_back(c[7:0]); fr.push_back(c[15:8]); fr.push_back(c[23:16]); fr.push_back(c[31:24]);
    for (int i = 0; i < 7; i++) drive(1'b1, (bad_pre != 0 && i == 2) ? 8'h5A : 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < fr.size(); i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      drive(1'b1, fr[i]);
    end
    if (stop_after < 0) drive(1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_data = 8'h00; local_mac_addr = LOCAL; promisc = 1'b0;
    mon_exp_ch = 0;
    clr_mon();

    vecs[0]  = '{LOCAL, 16'h0800,   46, 0, 1'b0,   46, 0, 1'b0, 1, 0, 0}; names[0]  = "ipv4";
    vecs[1]  = '{BCAST, 16'h0806,   46, 1, 1'b0,   46, 1, 1'b1, 0, 1, 0}; names[1]  = "arp_badfcs";
    vecs[2]  = '{OTHER, 16'h0800,   46, 0, 1'b0,    0, 0, 1'b0, 0, 0, 1}; names[2]  = "dst_miss";
    vecs[3]  = '{OTHER, 16'h0800,   46, 0, 1'b1,   46, 0, 1'b0, 1, 0, 0}; names[3]  = "promisc";
    vecs[4]  = '{LOCAL, 16'h1234,   46, 0, 1'b0,    0, 0, 1'b0, 0, 0, 1}; names[4]  = "etype_miss";
    vecs[5]  = '{LOCAL, 16'h88F7,   46, 0, 1'b0,   46, 3, 1'b0, 1, 0, 0}; names[5]  = "ptp";
    vecs[6]  = '{LOCAL, 16'h86DD,   10, 0, 1'b0,   10, 2, 1'b1, 0, 1, 0}; names[6]  = "runt10";
    vecs[7]  = '{BCAST, 16'h0800,    1, 0, 1'b0,    1, 0, 1'b1, 0, 1, 0}; names[7]  = "one_byte";
    vecs[8]  = '{LOCAL, 16'h0800,    0, 0, 1'b0,    0, 0, 1'b0, 0, 0, 1}; names[8]  = "empty";
    vecs[9]  = '{LOCAL, 16'h0800,   45, 0, 1'b0,   45, 0, 1'b1, 0, 1, 0}; names[9]  = "len63";
    vecs[10] = '{LOCAL, 16'h0806, 1500, 0, 1'b0, 1500, 1, 1'b0, 1, 0, 0}; names[10] = "len1518";
    vecs[11] = '{LOCAL, 16'h0800, 1504, 0, 1'b0, 1504, 0, 1'b0, 1, 0, 0}; names[11] = "len1522";
    vecs[12] = '{LOCAL, 16'h0800, 1505, 0, 1'b0, 1505, 0, 1'b1, 0, 1, 0}; names[12] = "len1523";
    vecs[13] = '{LOCAL, 16'h0800, 1582, 0, 1'b0, 1505, 0, 1'b1, 0, 1, 0}; names[13] = "len1600";

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset out_sop_eop_err", 64'({out_sop, out_eop, out_err}), 0);
    chk("reset out_src_mac", 64'(out_src_mac), 0);
    chk("reset stats", 64'({stat_good, stat_bad, stat_drop}), 0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 14; v++) begin
      logic [47:0] src;
      src = 48'h0A_00_00_00_10_00 + 48'(v);
      clr_mon();
      promisc    = vecs[v].prom;
      mon_exp_ch = vecs[v].ch;
      send_frame(vecs[v].dst, src, vecs[v].et, vecs[v].plen, vecs[v].flip, -1, v * 17 + 3, 0, -1);
      idle(10);
      chk($sformatf("%s beats", names[v]), 64'(mon_beats), 64'(vecs[v].beats));
      chk($sformatf("%s eops", names[v]), 64'(mon_eops), (vecs[v].beats > 0) ? 64'd1 : 64'd0);
      chk($sformatf("%s sop_errors", names[v]), 64'(mon_sop_bad), 0);
      chk($sformatf("%s data_errors", names[v]), 64'(mon_data_bad + mon_ch_bad), 0);
      chk($sformatf("%s stat_good", names[v]), 64'(mon_good), 64'(vecs[v].good));
      chk($sformatf("%s stat_bad", names[v]), 64'(mon_bad), 64'(vecs[v].bad));
      chk($sformatf("%s stat_drop", names[v]), 64'(mon_drop), 64'(vecs[v].drop));
      if (vecs[v].beats > 0) begin
        chk($sformatf("%s out_err", names[v]), 64'(mon_err_last), 64'(vecs[v].err));
        chk($sformatf("%s out_src_mac", names[v]), 64'(out_src_mac), 64'(src));
        chk($sformatf("%s out_vlan_id", names[v]), 64'(out_vlan_id), 0);
      end
    end
    promisc = 1'b0;

    // Corrupt preamble byte: the frame behind it must never be delivered.
    clr_mon();
    mon_exp_ch = 0;
    send_frame(LOCAL, 48'h0A_00_00_00_20_00, 16'h0800, 46, 0, -1, 7, 1, -1);
    idle(10);
    chk("badpre beats", 64'(mon_beats), 0);
    chk("badpre good_bad", 64'(mon_good + mon_bad), 0);

    // Reset in the middle of an ARP payload.
    clr_mon();
    mon_exp_ch = 1;
    send_frame(BCAST, 48'h0A_00_00_00_30_00, 16'h0806, 46, 0, -1, 9, 0, 44);
    chk("midrst beats_before", 64'(mon_beats > 0), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rx_dv = 1'b0;
    #1;
    chk("midrst out_valid", 64'(out_valid), 0);
    chk("midrst out_ch", 64'(out_ch), 0);
    chk("midrst out_src_mac", 64'(out_src_mac), 0);
    chk("midrst out_data", 64'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_mon();
    mon_exp_ch = 0;
    idle(2);
    send_frame(LOCAL, 48'h0A_00_00_00_40_00, 16'h0800, 46, 0, -1, 11, 0, -1);
    idle(10);
    chk("postrst beats", 64'(mon_beats), 46);
    chk("postrst good", 64'(mon_good), 1);
    chk("postrst errors", 64'(mon_data_bad + mon_sop_bad + mon_ch_bad + mon_bad), 0);
    chk("postrst out_src_mac", 64'(out_src_mac), 64'(48'h0A_00_00_00_40_00));

    // Back-to-back frames separated by a single idle cycle.
    clr_mon();
    mon_exp_ch = 0;
    send_frame(LOCAL, 48'h0A_00_00_00_50_00, 16'h0800, 46, 0, -1, 21, 0, -1);
    send_frame(LOCAL, 48'h0A_00_00_00_50_01, 16'h0800, 50, 0, -1, 77, 0, -1);
    idle(10);
    chk("b2b beats", 64'(mon_beats), 96);
    chk("b2b eops", 64'(mon_eops), 2);
    chk("b2b good", 64'(mon_good), 2);
    chk("b2b errors", 64'(mon_data_bad + mon_sop_bad + mon_ch_bad + mon_bad + mon_drop), 0);

    // VLAN-tagged IPv4 frame.
    clr_mon();
    mon_exp_ch = 0;
    send_frame(LOCAL, 48'h0A_00_00_00_60_00, 16'h0800, 46, 0, 16'h205A, 31, 0, -1);
    idle(10);
`ifdef MAC_RX_VLAN_EN
    chk("vlan beats", 64'(mon_beats), 46);
    chk("vlan good", 64'(mon_good), 1);
    chk("vlan errors", 64'(mon_data_bad + mon_sop_bad + mon_ch_bad), 0);
    chk("vlan out_vlan_id", 64'(out_vlan_id), 64'h05A);
`else
    chk("tagged beats", 64'(mon_beats), 0);
    chk("tagged drop", 64'(mon_drop), 1);
    chk("tagged out_vlan_id", 64'(out_vlan_id), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
